// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and constants for the push-button conditioner
package pb_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DN      = 2'd2,
        WAIT_UP = 2'd3
    } pb_state_t;

    localparam int   PB_SYNC_STAGES = 2;
    localparam logic PB_IDLE_LVL    = 1'b1;

endpackage

// File: rtl/pb_debounce_if.sv
// rtl/pb_debounce_if.sv - raw button input and conditioned outputs of one button
interface pb_debounce_if;

    logic PB;
    logic pb_dn;
    logic pb_up_n;
    logic pressed;
    logic released;
    logic long_press;

    // Button / consumer side: drives the raw contact, observes the clean outputs.
    modport master (
        output PB,
        input  pb_dn, pb_up_n, pressed, released, long_press
    );

    // Conditioner side.
    modport slave (
        input  PB,
        output pb_dn, pb_up_n, pressed, released, long_press
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module sync2
    import pb_pkg::*;
#(
    parameter logic RST_VAL = PB_IDLE_LVL
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [PB_SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; reset parks it at the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {PB_SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[PB_SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[PB_SYNC_STAGES-1];

endmodule

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - debounced level and strobes for one active-low button (option: PB_LONG_PRESS_EN)
module pb_debounce
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64
) (
    input  logic          clk,
    input  logic          rst,
    pb_debounce_if.slave  btn
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("pb_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("pb_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    logic      pb_s;
    pb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic      pb_dn_q, pb_dn_d;
    logic      pb_up_n_q;
    logic      pressed_q, pressed_d;
    logic      released_q, released_d;

    sync2 #(
        .RST_VAL (PB_IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn.PB),
        .q_o (pb_s)
    );

    // Debounce FSM. The sample that leaves UP/DN is the first of the run; cnt then
    // indexes the DEBOUNCE_CYCLES further samples taken in the wait state, so a
    // level is accepted only after DEBOUNCE_CYCLES+1 consecutive agreeing samples
    // at the FSM (two synchronizer cycles plus DEBOUNCE_CYCLES after the pin edge).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pb_dn_d    = pb_dn_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        unique case (state_q)
            UP: begin
                if (!pb_s) begin
                    state_d = WAIT_DN;
                    cnt_d   = '0;
                end
            end
            WAIT_DN: begin
                if (pb_s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d   = DN;
                    cnt_d     = '0;
                    pb_dn_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DN: begin
                if (pb_s) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (!pb_s) begin
                    state_d = DN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d    = UP;
                    cnt_d      = '0;
                    pb_dn_d    = 1'b0;
                    released_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
                pb_dn_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; pb_up_n has its own flop so the
    // reset synchronizer never sees an inverter glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UP;
            cnt_q      <= '0;
            pb_dn_q    <= 1'b0;
            pb_up_n_q  <= 1'b1;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pb_dn_q    <= pb_dn_d;
            pb_up_n_q  <= ~pb_dn_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign btn.pb_dn    = pb_dn_q;
    assign btn.pb_up_n  = pb_up_n_q;
    assign btn.pressed  = pressed_q;
    assign btn.released = released_q;

`ifdef PB_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter runs while debounced-pressed and saturates, so the terminal
    // value is crossed once per press; a release on the same edge wins.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == DN || state_q == WAIT_UP) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end
            if (hold_q == HOLD_MAX - HW'(1) && !released_d) begin
                long_d = 1'b1;
            end
        end else begin
            hold_d = '0;
        end
    end

    // Hold counter and long-press strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn.long_press = long_q;
`else
    assign btn.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - self-checking bench for pb_debounce against a run-length reference model
module tb_pb_debounce;
    import pb_pkg::*;

    localparam int D = 16;
    localparam int L = 64;
`ifdef PB_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pb_debounce_if bif ();

    pb_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tick_no  = 0;

    // Reference model: the pin reaches the decision logic two edges late; a new
    // level is accepted after D+1 consecutive opposing samples; long_press fires
    // when pb_dn has been 1 for L consecutive edges.
    bit m_d1 = 1'b1, m_d2 = 1'b1;
    bit m_lvl = 1'b0, m_pr = 1'b0, m_rl = 1'b0, m_lp = 1'b0;
    int m_run = 0, m_held = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b tick=%0d", tag, obs, exp, tick_no);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d tick=%0d", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_update(input bit pb, input bit r);
        bit s;
        bit was;
        if (r) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_held = 0;
            m_pr = 1'b0; m_rl = 1'b0; m_lp = 1'b0;
        end else begin
            s    = m_d2;
            was  = m_lvl;
            m_pr = 1'b0; m_rl = 1'b0; m_lp = 1'b0;
            if ((s == 1'b0) != m_lvl) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_lvl = !m_lvl;
                m_run = 0;
                m_pr  = m_lvl;
                m_rl  = !m_lvl;
            end
            if (was && m_lvl) begin
                m_held++;
                if (m_held == L && LP_EN) m_lp = 1'b1;
            end else begin
                m_held = 0;
            end
            m_d2 = m_d1;
            m_d1 = pb;
        end
    endtask

    task automatic step(input bit pb, input bit r);
        bif.PB = pb;
        rst    = r;
        @(posedge clk);
        model_update(pb, r);
        tick_no++;
        #1;
        check("pb_dn",      bif.pb_dn,      m_lvl);
        check("pb_up_n",    bif.pb_up_n,    !m_lvl);
        check("pressed",    bif.pressed,    m_pr);
        check("released",   bif.released,   m_rl);
        check("long_press", bif.long_press, m_lp);
    endtask

    // n = edges after the first edge of this call at which the strobe appears, -1 on timeout
    task automatic wait_strobe(input bit pb, input bit want_rel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(pb, 1'b0);
            if ((want_rel ? bif.released : bif.pressed) === 1'b1) begin
                n = i - 1;
                break;
            end
        end
    endtask

    int n;
    int strobes;
    int longs;
    int p_at, l_at;
    bit lvl;
    int seg;

    initial begin
        bif.PB = 1'b0;

        // Reset held with button pressed
        repeat (3) step(1'b0, 1'b1);
        check("rst_pb_dn",    bif.pb_dn,    1'b0);
        check("rst_pb_up_n",  bif.pb_up_n,  1'b1);
        check("rst_pressed",  bif.pressed,  1'b0);
        check("rst_released", bif.released, 1'b0);
        check("rst_long",     bif.long_press, 1'b0);

        wait_strobe(1'b0, 1'b0, 40, n);
        check_int("press_after_rst_latency", n, 18);
        step(1'b0, 1'b0);
        check("press_width", bif.pressed, 1'b0);
        check("pb_dn_held",  bif.pb_dn,   1'b1);
        repeat (5) step(1'b0, 1'b0);

        // Clean release
        wait_strobe(1'b1, 1'b1, 40, n);
        check_int("release_latency", n, 18);
        step(1'b1, 1'b0);
        check("release_width", bif.released, 1'b0);
        repeat (5) step(1'b1, 1'b0);

        // Bounce: toggle every 5 cycles, then settle low
        strobes = 0;
        for (int k = 0; k < 60; k++) begin
            step(((k / 5) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
            if (bif.pressed === 1'b1 || bif.released === 1'b1) strobes++;
        end
        check_int("bounce_no_strobe", strobes, 0);
        wait_strobe(1'b0, 1'b0, 40, n);
        check_int("bounce_press_latency", n, 18);
        wait_strobe(1'b1, 1'b1, 40, n);
        check_int("bounce_release_latency", n, 18);
        repeat (3) step(1'b1, 1'b0);

        // Glitch on the terminal sample: 16 low samples then one high
        strobes = 0;
        repeat (16) begin
            step(1'b0, 1'b0);
            if (bif.pressed === 1'b1) strobes++;
        end
        repeat (20) begin
            step(1'b1, 1'b0);
            if (bif.pressed === 1'b1) strobes++;
        end
        check_int("glitch_no_press", strobes, 0);
        check("glitch_state_up", dut.state_q === UP, 1'b1);
        check("glitch_cnt_zero", dut.cnt_q === 4'd0, 1'b1);

        // Reset mid-debounce at cnt=10
        repeat (13) step(1'b0, 1'b0);
        check("mid_state_wait", dut.state_q === WAIT_DN, 1'b1);
        check("mid_cnt_ten",    dut.cnt_q === 4'd10,     1'b1);
        step(1'b0, 1'b1);
        wait_strobe(1'b0, 1'b0, 40, n);
        check_int("press_after_mid_rst", n, 18);

        wait_strobe(1'b1, 1'b1, 40, n);
        check_int("release_before_long", n, 18);
        repeat (3) step(1'b1, 1'b0);

        // Long hold
        longs = 0; p_at = -1; l_at = -1;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0);
            if (bif.pressed === 1'b1) p_at = i;
            if (bif.long_press === 1'b1) begin
                longs++;
                l_at = i;
            end
        end
        check_int("long_count_first", longs, LP_EN ? 1 : 0);
`ifdef PB_LONG_PRESS_EN
        check_int("long_after_press", l_at - p_at, L);
`endif

        // Short hold then long hold again: re-arm after release
        longs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            if (bif.long_press === 1'b1) longs++;
        end
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0);
            if (bif.long_press === 1'b1) longs++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            if (bif.long_press === 1'b1) longs++;
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0);
            if (bif.long_press === 1'b1) longs++;
        end
        check_int("long_count_rearm", longs, LP_EN ? 1 : 0);

        // Random segments with bounce and occasional reset
        lvl = 1'b1;
        for (int s = 0; s < 60; s++) begin
            lvl = ~lvl;
            seg = $urandom_range(1, 45);
            for (int i = 0; i < seg; i++) begin
                if ($urandom_range(0, 99) == 0) step(lvl, 1'b1);
                else if ($urandom_range(0, 9) == 0) step(~lvl, 1'b0);
                else step(lvl, 1'b0);
            end
        end
        repeat (40) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
